slowfil_tap_loader: RTL

Writer-side companion for the slow shift-register FIR filters. It drives the filter's tap-write port (i_tap_wr/i_tap) from a host-loaded staging memory. It also sits in the filter's sample path:
- gates input samples while a coefficient set is being shifted in;
- optionally flushes the filter history with zero samples.

---
 rtl/slowfil_pkg.sv | 14 +
 rtl/slowfil_tap_ram.sv | 35 +++
 rtl/slowfil_tap_loader.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/slowfil_pkg.sv
// Shared state encoding and default widths for the slow shift-register FIR family.
package slowfil_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FLUSH
    } state_t;

    localparam int DEF_NTAPS = 128;
    localparam int DEF_TW    = 12;
    localparam int DEF_IW    = 12;

endpackage

// File: rtl/slowfil_tap_ram.sv
// Coefficient staging memory: one write port, one registered read port.
module slowfil_tap_ram
    import slowfil_pkg::*;
#(
    parameter int NTAPS = DEF_NTAPS,
    parameter int TW    = DEF_TW,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          wr,
    input  logic [AW-1:0] wr_addr,
    input  logic [TW-1:0] wr_data,
    input  logic          rd,
    input  logic [AW-1:0] rd_addr,
    output logic [TW-1:0] rd_data
);

    localparam int IDXW = $clog2(NTAPS);

    logic [TW-1:0] mem [NTAPS];
    logic          wr_ok;

    // Addresses beyond the tap count are dropped rather than aliased.
    assign wr_ok = wr && ({1'b0, wr_addr} < (AW+1)'(NTAPS));

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_addr[IDXW-1:0]] <= wr_data;
        end
        if (rd) begin
            rd_data <= mem[rd_addr[IDXW-1:0]];
        end
    end

endmodule

// File: rtl/slowfil_tap_loader.sv
// Streams a staged coefficient set into a slow FIR tap port, gating and optionally
// flushing the sample path so old history never meets new taps.
module slowfil_tap_loader
    import slowfil_pkg::*;
#(
    parameter int NTAPS     = DEF_NTAPS,
    parameter int TW        = DEF_TW,
    parameter int IW        = DEF_IW,
    parameter int AW        = 7,
    parameter int FLUSH     = 1,
    parameter int FLUSH_GAP = 128
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_wr,
    input  logic [AW-1:0] i_addr,
    input  logic [TW-1:0] i_data,
    input  logic          i_commit,
    output logic          o_busy,
    input  logic          i_ce,
    input  logic [IW-1:0] i_sample,
    output logic          o_tap_wr,
    output logic [TW-1:0] o_tap,
    output logic          o_ce,
    output logic [IW-1:0] o_sample,
    output logic          o_dropped
);

    localparam int           GW    = $clog2(FLUSH_GAP + 1);
    localparam logic [AW:0]  NT_C  = (AW+1)'(NTAPS);

    state_t         state, state_nxt;
    logic [AW-1:0]  rd_cnt;
    logic           rd_done;
    logic [GW-1:0]  gap_cnt;
    logic [AW:0]    flush_cnt;
    logic           rd_en;
    logic           fire;
    logic           load_exit;
    logic           tap_wr_p1;
    logic [TW-1:0]  rd_data_p1;

    slowfil_tap_ram #(
        .NTAPS (NTAPS),
        .TW    (TW),
        .AW    (AW)
    ) u_ram (
        .clk     (i_clk),
        .wr      (i_wr),
        .wr_addr (i_addr),
        .wr_data (i_data),
        .rd      (rd_en),
        .rd_addr (rd_cnt),
        .rd_data (rd_data_p1)
    );

    // rd_done marks the cycle where the address-0 tap is on the port.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        fire      = 1'b0;
        load_exit = 1'b0;
        case (state)
            slowfil_pkg::IDLE: begin
                if (i_commit) begin
                    state_nxt = slowfil_pkg::LOAD;
                end
            end
            slowfil_pkg::LOAD: begin
                rd_en = !rd_done;
                if (rd_done) begin
                    load_exit = 1'b1;
                    state_nxt = (FLUSH != 0) ? slowfil_pkg::FLUSH : slowfil_pkg::IDLE;
                    fire      = (FLUSH != 0) && (FLUSH_GAP == 1);
                end
            end
            slowfil_pkg::FLUSH: begin
                fire = (gap_cnt == GW'(1)) && (flush_cnt < NT_C);
                if (o_ce && (flush_cnt == NT_C)) begin
                    state_nxt = slowfil_pkg::IDLE;
                end
            end
            default: state_nxt = slowfil_pkg::IDLE;
        endcase
    end

    // Stage p1: registered tap strobe alongside RAM read data, sample path, counters.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= slowfil_pkg::IDLE;
            rd_cnt    <= '0;
            rd_done   <= 1'b0;
            gap_cnt   <= '0;
            flush_cnt <= '0;
            tap_wr_p1 <= 1'b0;
            o_ce      <= 1'b0;
            o_sample  <= '0;
            o_dropped <= 1'b0;
        end else begin
            state     <= state_nxt;
            tap_wr_p1 <= rd_en;
            o_dropped <= i_ce && (state != slowfil_pkg::IDLE);

            if (state == slowfil_pkg::IDLE) begin
                o_ce     <= i_ce;
                o_sample <= i_sample;
            end else begin
                o_ce     <= fire;
                o_sample <= '0;
            end

            if ((state == slowfil_pkg::IDLE) && i_commit) begin
                rd_cnt    <= AW'(NTAPS - 1);
                rd_done   <= 1'b0;
                flush_cnt <= '0;
            end

            if (rd_en) begin
                if (rd_cnt == '0) begin
                    rd_done <= 1'b1;
                end else begin
                    rd_cnt <= rd_cnt - 1'b1;
                end
            end

            // The gap counter reloads on every strobe so spacing is exact.
            if (fire) begin
                gap_cnt   <= GW'(FLUSH_GAP);
                flush_cnt <= flush_cnt + 1'b1;
            end else if (load_exit) begin
                gap_cnt <= GW'(FLUSH_GAP - 1);
            end else if (state == slowfil_pkg::FLUSH) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
        end
    end

    assign o_busy   = (state != slowfil_pkg::IDLE);
    assign o_tap_wr = tap_wr_p1;
    assign o_tap    = tap_wr_p1 ? rd_data_p1 : '0;

endmodule
